// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the unified-memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int READ_LAT_DEFAULT = 1;
  localparam int READ_LAT_MAX     = 4;
  localparam int CNT_W            = 2;

  // One latched bus transaction.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick; ties go to whoever was not granted last.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  input  logic grant_en,
  output logic grant_d
);

  logic last_d;

  // Only D, or both with I granted last, selects D.
  assign grant_d = req_d & (~req_i | ~last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (grant_en) begin
      last_d <= grant_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous memory port between the instruction-fetch (Iw) and data (Dw) buses.
// Handshake: a requester raises req with stable fields and holds them until its one-cycle ack.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int READ_LAT = READ_LAT_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIwReq,
  input  logic        iDwReq,
  input  logic        iIwWE,
  input  logic        iDwWE,
  input  logic [3:0]  iIwBE,
  input  logic [3:0]  iDwBE,
  input  logic [31:0] iIwAddr,
  input  logic [31:0] iDwAddr,
  input  logic [31:0] iIwWData,
  input  logic [31:0] iDwWData,
  output logic        oIwAck,
  output logic        oDwAck,
  output logic [31:0] oIwRData,
  output logic [31:0] oDwRData,
  output logic        oMemRE,
  output logic        oMemWE,
  output logic [3:0]  oMemBE,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  input  logic [31:0] iMemRData,
  output logic        oBusy,
  output logic        oOwnerD,
  output state_t      oState
);

  if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("mem_bus_arbiter: READ_LAT %0d outside 1..%0d", READ_LAT, READ_LAT_MAX);
  end

  state_t           state, state_nxt;
  txn_t             txn_q, txn_pick;
  logic             owner_d;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_i_q, rdata_d_q;
  logic             any_req, grant, pick_d, capture;

  assign any_req = iIwReq | iDwReq;
  assign grant   = (state == IDLE) && any_req;
  assign capture = (state == WAIT) && (cnt == '0);

  rr_arbiter2 u_rr (
    .clk      (iCLK),
    .rst_n    (iRST),
    .req_i    (iIwReq),
    .req_d    (iDwReq),
    .grant_en (grant),
    .grant_d  (pick_d)
  );

  assign txn_pick = pick_d ? '{we: iDwWE, be: iDwBE, addr: iDwAddr, wdata: iDwWData}
                           : '{we: iIwWE, be: iIwBE, addr: iIwAddr, wdata: iIwWData};

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = txn_q.we ? DONE : WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oMemRE = (state == ISSUE) && !txn_q.we;
    oMemWE = (state == ISSUE) && txn_q.we;
    oMemBE = (state == ISSUE) ? txn_q.be : 4'h0;
    oIwAck = (state == DONE) && !owner_d;
    oDwAck = (state == DONE) && owner_d;
    oBusy  = (state != IDLE);
  end

  // Latches, latency counter and per-requester read data.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      txn_q     <= '0;
      owner_d   <= 1'b0;
      cnt       <= '0;
      rdata_i_q <= '0;
      rdata_d_q <= '0;
    end else begin
      if (grant) begin
        txn_q   <= txn_pick;
        owner_d <= pick_d;
      end
      if (state == ISSUE && !txn_q.we) begin
        cnt <= CNT_W'(READ_LAT - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture && owner_d) begin
        rdata_d_q <= iMemRData;
      end
      if (capture && !owner_d) begin
        rdata_i_q <= iMemRData;
      end
    end
  end

  // Address and write data stay on the bus between commands.
  assign oMemAddr  = txn_q.addr;
  assign oMemWData = txn_q.wdata;
  assign oOwnerD   = owner_d;
  assign oIwRData  = rdata_i_q;
  assign oDwRData  = rdata_d_q;
  assign oState    = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: main instance at READ_LAT=3 plus a latency sweep at 1, 2, 4.
module tb_mem_bus_arbiter;

  localparam int MAIN_LAT = 3;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iIwReq, iDwReq, iIwWE, iDwWE;
  logic [3:0]  iIwBE, iDwBE;
  logic [31:0] iIwAddr, iDwAddr, iIwWData, iDwWData;
  logic        oIwAck, oDwAck, oMemRE, oMemWE, oBusy, oOwnerD;
  logic [31:0] oIwRData, oDwRData, oMemAddr, oMemWData, iMemRData;
  logic [3:0]  oMemBE;
  logic [1:0]  oState;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd_i, exp_rd_d;
  vec_t        vecs[7];

  // Sweep instances: index 0/1/2 = READ_LAT 1/2/4.
  logic        sw_req;
  logic        s_iack [3], s_dack [3], s_re [3], s_we [3], s_busy [3], s_own [3];
  logic [3:0]  s_be [3];
  logic [31:0] s_irdata [3], s_drdata [3], s_addr [3], s_wdata [3], s_mdata [3];
  logic [1:0]  s_state [3];
  int          s_q0[$], s_q1[$], s_q2[$];
  bit          s_bad = 1'b0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h8C00_0010;
  endfunction

  // ---------------- clock / reset ----------------
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  mem_bus_arbiter #(.READ_LAT(MAIN_LAT)) u_dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIwReq(iIwReq), .iDwReq(iDwReq), .iIwWE(iIwWE), .iDwWE(iDwWE),
    .iIwBE(iIwBE), .iDwBE(iDwBE), .iIwAddr(iIwAddr), .iDwAddr(iDwAddr),
    .iIwWData(iIwWData), .iDwWData(iDwWData),
    .oIwAck(oIwAck), .oDwAck(oDwAck), .oIwRData(oIwRData), .oDwRData(oDwRData),
    .oMemRE(oMemRE), .oMemWE(oMemWE), .oMemBE(oMemBE), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .iMemRData(iMemRData),
    .oBusy(oBusy), .oOwnerD(oOwnerD), .oState(oState)
  );

  mem_bus_arbiter #(.READ_LAT(1)) u_s1 (
    .iCLK(iCLK), .iRST(iRST),
    .iIwReq(sw_req), .iDwReq(1'b0), .iIwWE(1'b0), .iDwWE(1'b0),
    .iIwBE(4'hF), .iDwBE(4'h0), .iIwAddr(32'h80), .iDwAddr(32'h0),
    .iIwWData(32'h0), .iDwWData(32'h0),
    .oIwAck(s_iack[0]), .oDwAck(s_dack[0]), .oIwRData(s_irdata[0]), .oDwRData(s_drdata[0]),
    .oMemRE(s_re[0]), .oMemWE(s_we[0]), .oMemBE(s_be[0]), .oMemAddr(s_addr[0]),
    .oMemWData(s_wdata[0]), .iMemRData(s_mdata[0]),
    .oBusy(s_busy[0]), .oOwnerD(s_own[0]), .oState(s_state[0])
  );

  mem_bus_arbiter #(.READ_LAT(2)) u_s2 (
    .iCLK(iCLK), .iRST(iRST),
    .iIwReq(sw_req), .iDwReq(1'b0), .iIwWE(1'b0), .iDwWE(1'b0),
    .iIwBE(4'hF), .iDwBE(4'h0), .iIwAddr(32'h80), .iDwAddr(32'h0),
    .iIwWData(32'h0), .iDwWData(32'h0),
    .oIwAck(s_iack[1]), .oDwAck(s_dack[1]), .oIwRData(s_irdata[1]), .oDwRData(s_drdata[1]),
    .oMemRE(s_re[1]), .oMemWE(s_we[1]), .oMemBE(s_be[1]), .oMemAddr(s_addr[1]),
    .oMemWData(s_wdata[1]), .iMemRData(s_mdata[1]),
    .oBusy(s_busy[1]), .oOwnerD(s_own[1]), .oState(s_state[1])
  );

  mem_bus_arbiter #(.READ_LAT(4)) u_s4 (
    .iCLK(iCLK), .iRST(iRST),
    .iIwReq(sw_req), .iDwReq(1'b0), .iIwWE(1'b0), .iDwWE(1'b0),
    .iIwBE(4'hF), .iDwBE(4'h0), .iIwAddr(32'h80), .iDwAddr(32'h0),
    .iIwWData(32'h0), .iDwWData(32'h0),
    .oIwAck(s_iack[2]), .oDwAck(s_dack[2]), .oIwRData(s_irdata[2]), .oDwRData(s_drdata[2]),
    .oMemRE(s_re[2]), .oMemWE(s_we[2]), .oMemBE(s_be[2]), .oMemAddr(s_addr[2]),
    .oMemWData(s_wdata[2]), .iMemRData(s_mdata[2]),
    .oBusy(s_busy[2]), .oOwnerD(s_own[2]), .oState(s_state[2])
  );

  // ---------------- memory models ----------------
  // Main memory: read data appears exactly MAIN_LAT cycles after the command cycle.
  logic        pipe_v [1:MAIN_LAT];
  logic [31:0] pipe_d [1:MAIN_LAT];
  always @(posedge iCLK) begin
    pipe_v[1] <= oMemRE;
    pipe_d[1] <= mem_f(oMemAddr);
    for (int i = 2; i <= MAIN_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign iMemRData = pipe_v[MAIN_LAT] ? pipe_d[MAIN_LAT] : 32'hBAD0_BAD0;

  assign s_mdata[0] = mem_f(s_addr[0]);
  assign s_mdata[1] = mem_f(s_addr[1]);
  assign s_mdata[2] = mem_f(s_addr[2]);

  // Sweep ack recorder and sanity monitor.
  always @(negedge iCLK) begin
    if (s_iack[0]) s_q0.push_back(cyc);
    if (s_iack[1]) s_q1.push_back(cyc);
    if (s_iack[2]) s_q2.push_back(cyc);
    for (int j = 0; j < 3; j++) begin
      if (s_dack[j] || s_we[j] || s_own[j] || (s_iack[j] && s_irdata[j] != 32'h8C00_0090)) s_bad = 1'b1;
      if (s_re[j] && (s_be[j] != 4'hF || s_wdata[j] != 32'h0 || s_state[j] != 2'd1)) s_bad = 1'b1;
      if (s_drdata[j] != 32'h0 || (s_busy[j] && !sw_req && s_iack[j] && s_dack[j])) s_bad = 1'b1;
    end
  end

  // req must stay high until the owner's ack.
  always @(posedge iCLK) begin
    if (iRST) begin
      if (oBusy && !oOwnerD && !oIwAck) assert (iIwReq) else $error("iIwReq dropped before ack");
      if (oBusy && oOwnerD && !oDwAck) assert (iDwReq) else $error("iDwReq dropped before ack");
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acks"}, {30'd0, oIwAck, oDwAck}, 32'd0);
    check({tag, "_strobes"}, {26'd0, oMemRE, oMemWE, oMemBE}, 32'd0);
    check({tag, "_addr"}, oMemAddr, 32'd0);
    check({tag, "_wdata"}, oMemWData, 32'd0);
    check({tag, "_irdata"}, oIwRData, 32'd0);
    check({tag, "_drdata"}, oDwRData, 32'd0);
    check({tag, "_busy_owner_state"}, {28'd0, oBusy, oOwnerD, oState}, 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Called on a negedge with the arbiter idle; returns on the negedge of the following IDLE cycle.
  task automatic run_vec(input vec_t v);
    int   n;
    bit   seen, quiet;
    logic [31:0] got;
    if (v.is_d) begin
      iDwReq = 1'b1; iDwWE = v.we; iDwBE = v.be; iDwAddr = v.addr; iDwWData = v.wdata;
    end else begin
      iIwReq = 1'b1; iIwWE = v.we; iIwBE = v.be; iIwAddr = v.addr; iIwWData = v.wdata;
    end
    @(posedge iCLK);
    @(negedge iCLK);
    check("issue_state", oState, 2'd1);
    check("issue_we_re", {oMemWE, oMemRE}, {v.we, ~v.we});
    check("issue_be", oMemBE, v.be);
    check("issue_addr", oMemAddr, v.addr);
    check("issue_wdata", oMemWData, v.wdata);
    check("issue_owner", oOwnerD, v.is_d);
    if (!v.we) exp_q.push_back(v.exp_rdata);
    n = 1; seen = 1'b0; quiet = 1'b1;
    while (!seen && n < 12) begin
      @(negedge iCLK);
      n++;
      if (oMemRE || oMemWE || oMemBE != 4'h0) quiet = 1'b0;
      if (v.is_d ? oIwAck : oDwAck) quiet = 1'b0;
      if (v.is_d ? oDwAck : oIwAck) seen = 1'b1;
    end
    check("ack_seen", seen, 1'b1);
    check("ack_latency", n, v.exp_lat);
    check("quiet_outside_issue", quiet, 1'b1);
    check("ack_state", oState, 2'd3);
    check("addr_held", oMemAddr, v.addr);
    if (!v.we && exp_q.size() > 0) begin
      got = v.is_d ? oDwRData : oIwRData;
      check("rdata", got, exp_q.pop_front());
      if (v.is_d) exp_rd_d = v.exp_rdata; else exp_rd_i = v.exp_rdata;
    end
    if (v.is_d) iDwReq = 1'b0; else iIwReq = 1'b0;
    @(negedge iCLK);
    check("ack_one_cycle", {30'd0, oIwAck, oDwAck}, 32'd0);
    check("idle_busy", oBusy, 1'b0);
    check("irdata_model", oIwRData, exp_rd_i);
    check("drdata_model", oDwRData, exp_rd_d);
  endtask

  task automatic contention();
    int  n;
    bit  who;
    iIwReq = 1'b1; iIwWE = 1'b0; iIwBE = 4'hF; iIwAddr = 32'h10; iIwWData = 32'h0;
    iDwReq = 1'b1; iDwWE = 1'b1; iDwBE = 4'hF; iDwAddr = 32'h300; iDwWData = 32'h1111_2222;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge iCLK);
        n++;
      end while (!(oIwAck || oDwAck) && n < 20);
      check("contend_ack_seen", oIwAck | oDwAck, 1'b1);
      check("contend_no_overlap", oIwAck & oDwAck, 1'b0);
      who = oDwAck;
      check("contend_grant_order", who, (k % 2 == 0) ? 1'b1 : 1'b0);
      check("contend_owner", oOwnerD, (k % 2 == 0) ? 1'b1 : 1'b0);
      if (!who) check("contend_irdata", oIwRData, 32'h8C00_0000);
    end
    iIwReq = 1'b0; iDwReq = 1'b0;
    exp_rd_i = 32'h8C00_0000;
    @(negedge iCLK);
    check("contend_idle", oBusy, 1'b0);
    check("contend_drdata_untouched", oDwRData, 32'h0);
  endtask

  task automatic reset_mid();
    bit quiet;
    vec_t again;
    iIwReq = 1'b1; iIwWE = 1'b0; iIwBE = 4'hF; iIwAddr = 32'h20; iIwWData = 32'h0;
    @(posedge iCLK);
    @(negedge iCLK);
    @(negedge iCLK);
    @(negedge iCLK);
    check("mid_in_wait", oState, 2'd2);
    #2 iRST = 1'b0;
    #1 check_reset_outputs("mid_reset");
    iIwReq = 1'b0;
    exp_rd_i = 32'h0; exp_rd_d = 32'h0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge iCLK);
      if (oIwAck || oDwAck || oBusy) quiet = 1'b0;
    end
    check("mid_no_ack", quiet, 1'b1);
    iRST = 1'b1;
    @(negedge iCLK);
    again = '{1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h8C00_0030, MAIN_LAT + 2};
    run_vec(again);
  endtask

  task automatic sweep();
    @(negedge iCLK);
    sw_req = 1'b1;
    repeat (32) @(negedge iCLK);
    sw_req = 1'b0;
    repeat (10) @(negedge iCLK);
    check("sweep_l1_count", s_q0.size() >= 3, 1'b1);
    check("sweep_l2_count", s_q1.size() >= 3, 1'b1);
    check("sweep_l4_count", s_q2.size() >= 3, 1'b1);
    if (s_q0.size() >= 3) begin
      check("sweep_l1_spacing_a", s_q0[1] - s_q0[0], 4);
      check("sweep_l1_spacing_b", s_q0[2] - s_q0[1], 4);
    end
    if (s_q1.size() >= 3) begin
      check("sweep_l2_spacing_a", s_q1[1] - s_q1[0], 5);
      check("sweep_l2_spacing_b", s_q1[2] - s_q1[1], 5);
    end
    if (s_q2.size() >= 3) begin
      check("sweep_l4_spacing_a", s_q2[1] - s_q2[0], 7);
      check("sweep_l4_spacing_b", s_q2[2] - s_q2[1], 7);
    end
    check("sweep_sanity", s_bad, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    iRST = 1'b0; sw_req = 1'b0;
    iIwReq = 1'b0; iDwReq = 1'b0; iIwWE = 1'b0; iDwWE = 1'b0;
    iIwBE = 4'h0; iDwBE = 4'h0; iIwAddr = 32'h0; iDwAddr = 32'h0;
    iIwWData = 32'h0; iDwWData = 32'h0;
    exp_rd_i = 32'h0; exp_rd_d = 32'h0;

    //          is_d  we    be    addr           wdata          exp_rdata      exp_lat
    vecs[0] = '{1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         2};
    vecs[1] = '{1'b0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h8C00_0010, 5};
    vecs[2] = '{1'b1, 1'b0, 4'h3, 32'h0000_0202, 32'h0,         32'h8C00_0212, 5};
    vecs[3] = '{1'b0, 1'b1, 4'h0, 32'h0000_0044, 32'h0BAD_F00D, 32'h0,         2};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_01FC, 32'h0,         32'h8C00_01EC, 5};
    vecs[5] = '{1'b1, 1'b0, 4'hC, 32'hFFFF_FFF0, 32'h5555_AAAA, 32'h73FF_FFE0, 5};
    vecs[6] = '{1'b1, 1'b1, 4'h5, 32'h0000_0008, 32'hCAFE_0001, 32'h0,         2};

    #12 check_reset_outputs("por");
    @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);

    contention();
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    reset_mid();
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares a single synchronous memory port between the CPU instruction-fetch requester (Iw) and the data requester (Dw). Sits between the processor's two buses and a unified instruction/data RAM. Uses a per-transaction req/ack handshake, round-robin arbitration and a configurable memory read latency. Serves as the bus controller for the unified-memory build and for the multicycle datapath, which stall on ack.

## Interface
- READ_LAT, 1, memory read latency in cycles (legal 1..4): data valid READ_LAT cycles after the command cycle.
- iCLK  in  1  single clock, rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iIwReq, iDwReq  in  1 each  transaction request; must be held with its fields stable until the matching ack.
- iIwWE, iDwWE  in  1 each  1 = write, 0 = read.
- iIwBE, iDwBE  in  4 each  byte enables, passed through unchanged.
- iIwAddr, iDwAddr  in  32 each  byte address, passed through unchanged.
- iIwWData, iDwWData  in  32 each  write data.
- oIwAck, oDwAck  out  1 each  one-cycle completion pulse.
- oIwRData, oDwRData  out  32 each  registered read data, valid in the ack cycle and held until that requester's next read capture.
- oMemRE, oMemWE  out  1  memory command strobes.
- oMemBE  out  4  memory byte enables.
- oMemAddr, oMemWData  out  32  memory address and write data.
- iMemRData  in  32  memory read data.
- oBusy  out  1  high whenever the arbiter is not IDLE.
- oOwnerD  out  1  owner of the current or last transaction: 1 = Dw, 0 = Iw.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high at an edge, latch the winner's WE, BE, Addr and WData, set the owner, and go to ISSUE.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: grant the requester not granted last, using the lastD flag. lastD resets to 0, so Dw wins the first tie.
  - lastD is updated on every grant.
- ISSUE:
  - Lasts exactly one cycle. Drives oMemRE = ~WE, oMemWE = WE, and oMemBE/Addr/WData from the latched registers.
  - Write: go to DONE.
  - Read: go to WAIT and load the counter with READ_LAT-1.
- WAIT:
  - Lasts READ_LAT cycles; the counter decrements each cycle.
  - When the counter is 0, capture iMemRData into the owner's RData register at that edge and go to DONE.
- DONE:
  - Assert the owner's ack for one cycle, then return to IDLE unconditionally.
  - req values seen at the DONE-exit edge are ignored. A requester holding req high gets a fresh transaction sampled at the following edge.
- Outside ISSUE: oMemRE = oMemWE = 0 and oMemBE = 0. oMemAddr and oMemWData hold their last values.
- A read with BE = 0 is still issued and still acked.
- The non-owner's RData register is never modified.

## Timing
- Sampling edge k (IDLE with req): ISSUE occupies cycle k+1, meaning the cycle that follows edge k.
- Read:
  - WAIT covers cycles k+2 .. k+1+READ_LAT.
  - Capture happens at the end of cycle k+1+READ_LAT.
  - Ack is high in cycle k+2+READ_LAT.
- Write: ack is high in cycle k+2, for a 3-cycle period per transaction.
- Back-to-back throughput with req held high: one transaction every 3 cycles (write) or READ_LAT+3 cycles (read).
- Under sustained contention the requesters alternate strictly; the maximum wait for either requester is one full transaction of the other.
- Reset values:
  - state IDLE, lastD = 0, counter 0.
  - all acks 0, oMemRE/WE 0, oMemBE 0, oMemAddr/WData 0.
  - both RData registers 0, oBusy 0, oOwnerD 0.
- Reset asserted mid-transaction:
  - Aborts immediately and asynchronously; no ack is issued and no RData is captured.
  - If reset lands in ISSUE, the memory command is dropped.
  - Requesters re-request after reset is released.
- req dropped before ack: protocol violation. The arbiter completes the transaction anyway and still pulses ack; the bench flags the violation with an assertion.

## Structure
- Shared parameter header holds:
  - state encodings: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3.
  - READ_LAT default and maximum legal value (4).
  - counter width (2 bits).
- Sub-module: rr_arbiter2, a two-requester round-robin pick with a lastD register, updated on its grant-enable input.
- Top module contains the FSM, request latches, latency counter and RData registers.
- Elaboration check: READ_LAT outside 1..4 is an error.

## Test plan
- Single Dw write, Addr = 0x100, WData = 0xDEADBEEF, BE = 0xF → oMemWE high only in cycle k+1 with matching fields; oDwAck in cycle k+2; oIwAck stays 0.
- Iw read of 0x0 with READ_LAT = 3, memory model returns 0x8C000010 → oIwAck in cycle k+5 with oIwRData = 0x8C000010; oDwRData unchanged.
- Both reqs high from reset, held for 4 transactions → grant order D, I, D, I; oOwnerD toggles each transaction; no ack overlap.
- Dw read with BE = 0x3 at 0x202 → oMemBE = 0x3 and oMemAddr = 0x202 in ISSUE; ack and RData correct.
- iRST low during WAIT of an Iw read → all outputs at reset values immediately; no ack; after release, a re-issued read completes normally.
- Sweep READ_LAT = 1, 2, 4 with back-to-back reads → ack spacing of 4, 5 and 7 cycles respectively.
